// File: rtl/max_frame_reducer.sv
// max_frame_reducer
// Folds a valid/ready stream of unsigned samples into a running maximum and
// reports one maximum (plus sample count) per frame of FRAME_LEN samples, or
// per shorter frame when flush closes it early.
// Optional build macro: MAX_FRAME_REDUCER_INDEX_EN adds out_idx, the 0-based
// position of the first sample in the frame that equals out_max.
module max_frame_reducer #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_count
`ifdef MAX_FRAME_REDUCER_INDEX_EN
    ,
    output logic [CNT_W-1:0] out_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] out_max_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             in_ready_reg;
    logic             load_out;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

`ifdef MAX_FRAME_REDUCER_INDEX_EN
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] out_idx_reg;
`endif

    // Operand pair and select handed to the downstream combinational max
    // slices: the registered running max, the incoming sample, and the
    // strict-greater decision (ties keep the earlier sample).
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_sel;
    logic [WIDTH-1:0] max_sel;

    assign cmp_a   = max_reg;
    assign cmp_b   = in_data;
    assign cmp_sel = (cmp_b > cmp_a);

    // Per-bit select between the held maximum and the new sample.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_max_sel
            assign max_sel[gi] = cmp_sel ? cmp_b[gi] : cmp_a[gi];
        end
    endgenerate

    // in_ready is purely registered so out_ready never reaches it combinationally.
    assign accept  = in_valid & in_ready_reg;
    assign cnt_inc = cnt_reg + ONE_C;

    // Next-state logic: accumulate samples, close the frame on length or flush,
    // and release the held result on the output handshake.
    always_comb begin
        state_next = state_reg;
        max_next   = max_reg;
        cnt_next   = cnt_reg;
        load_out   = 1'b0;
`ifdef MAX_FRAME_REDUCER_INDEX_EN
        idx_next   = idx_reg;
`endif
        case (state_reg)
            IDLE: begin
                // flush with an empty frame is ignored: no empty results.
                if (accept) begin
                    max_next   = in_data;
                    cnt_next   = ONE_C;
                    state_next = ACC;
`ifdef MAX_FRAME_REDUCER_INDEX_EN
                    idx_next   = '0;
`endif
                end
            end
            ACC: begin
                if (accept) begin
                    max_next = max_sel;
                    cnt_next = cnt_inc;
`ifdef MAX_FRAME_REDUCER_INDEX_EN
                    if (cmp_sel) begin
                        idx_next = cnt_reg;
                    end
`endif
                end
                // A sample accepted alongside flush is folded in before closing.
                if ((accept && (cnt_inc == FRAME_LEN_C)) || flush) begin
                    state_next = HOLD;
                    load_out   = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    max_next   = '0;
                    cnt_next   = '0;
`ifdef MAX_FRAME_REDUCER_INDEX_EN
                    idx_next   = '0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                max_next   = '0;
                cnt_next   = '0;
`ifdef MAX_FRAME_REDUCER_INDEX_EN
                idx_next   = '0;
`endif
            end
        endcase
    end

    // State, running max and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            max_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            max_reg   <= max_next;
            cnt_reg   <= cnt_next;
        end
    end

    // in_ready is low through reset, low while a result is held, and rises
    // only the cycle after the handshake that frees the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_reg <= 1'b0;
        end else begin
            in_ready_reg <= (state_next != HOLD);
        end
    end

    // Result registers: captured on the transition into HOLD and held stable
    // until the downstream handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_max_reg   <= '0;
            out_count_reg <= '0;
        end else if (load_out) begin
            out_max_reg   <= max_next;
            out_count_reg <= cnt_next;
        end
    end

`ifdef MAX_FRAME_REDUCER_INDEX_EN
    // Position of the first maximum within the frame and its reported copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg     <= '0;
            out_idx_reg <= '0;
        end else begin
            idx_reg <= idx_next;
            if (load_out) begin
                out_idx_reg <= idx_next;
            end
        end
    end

    assign out_idx = out_idx_reg;
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == HOLD);
    assign out_max   = out_max_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_max_frame_reducer.sv
// tb_max_frame_reducer
// Directed plus randomized stimulus against a frame-level reference model.
// Expected results go into a scoreboard queue; a monitor pops and checks each
// result as the DUT presents it. Build with MAX_FRAME_REDUCER_INDEX_EN to also
// check out_idx.
module tb_max_frame_reducer;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_count;
`ifdef MAX_FRAME_REDUCER_INDEX_EN
    logic [CNT_W-1:0] out_idx;
`endif

    max_frame_reducer #(
        .WIDTH    (WIDTH),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_max  (out_max),
        .out_count(out_count)
`ifdef MAX_FRAME_REDUCER_INDEX_EN
        ,
        .out_idx  (out_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] mx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the samples of the open frame, whether a result is
    // pending downstream, and the predicted in_ready.
    int unsigned frame_q[$];
    bit          exp_hold  = 1'b0;
    bit          exp_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame result from first principles: largest value, its first position, size.
    function automatic exp_t summarize();
        exp_t e;
        int   best = 0;
        for (int i = 1; i < frame_q.size(); i++) begin
            if (frame_q[i] > frame_q[best]) best = i;
        end
        e.mx  = WIDTH'(frame_q[best]);
        e.cnt = CNT_W'(frame_q.size());
        e.idx = CNT_W'(best);
        return e;
    endfunction

    // One clock: check handshake outputs, drive inputs, advance the model.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit f,
                        input bit ordy, input bit r, output bit accepted);
        bit had;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_hold));
        in_valid  = v;
        in_data   = v ? d : 'x;
        flush     = f;
        out_ready = ordy;
        rst       = r;
        accepted  = 1'b0;
        if (r) begin
            frame_q.delete();
            exp_hold  = 1'b0;
            exp_ready = 1'b0;
        end else begin
            accepted = v && exp_ready;
            if (exp_hold) begin
                if (ordy) exp_hold = 1'b0;
            end else begin
                had = (frame_q.size() > 0);
                if (accepted) frame_q.push_back(int'(d));
                if ((frame_q.size() == FRAME_LEN) || (f && had)) begin
                    sb.push_back(summarize());
                    frame_q.delete();
                    exp_hold = 1'b1;
                end
            end
            exp_ready = !exp_hold;
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ordy, 1'b0, a);
    endtask

    // Offer one sample until accepted, within a bounded number of cycles.
    task automatic send(input logic [WIDTH-1:0] d, input bit f, input bit ordy);
        bit a;
        int tries = 0;
        a = 1'b0;
        while (!a && tries < 20) begin
            step(1'b1, d, f, ordy, 1'b0, a);
            tries++;
        end
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
        end
    endtask

    // Monitor: pops the expected result when out_valid rises, then checks it
    // stays stable for as long as it is presented.
    initial begin
        exp_t cur;
        bit   seen;
        cur  = '0;
        seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=max_%0h required=no_result", out_max);
                    end else begin
                        cur = sb.pop_front();
                        $display("result max=%0h count=%0d", out_max, out_count);
                        chk("out_max", 32'(out_max), 32'(cur.mx));
                        chk("out_count", 32'(out_count), 32'(cur.cnt));
`ifdef MAX_FRAME_REDUCER_INDEX_EN
                        chk("out_idx", 32'(out_idx), 32'(cur.idx));
`endif
                    end
                end else begin
                    chk("out_max_stable", 32'(out_max), 32'(cur.mx));
                    chk("out_count_stable", 32'(out_count), 32'(cur.cnt));
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        bit a;
        // Reset state.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        chk("reset_out_max", 32'(out_max), 32'h0);
        chk("reset_out_count", 32'(out_count), 32'h0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        idle(2, 1'b1);

        // Back-to-back full frame.
        send(8'h12, 1'b0, 1'b1);
        send(8'h7F, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        send(8'h05, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Ties keep the earliest sample.
        send(8'h40, 1'b0, 1'b1);
        send(8'h40, 1'b0, 1'b1);
        send(8'h10, 1'b0, 1'b1);
        send(8'h40, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Short frame closed by flush in an idle cycle, then flush on an empty frame.
        send(8'hA0, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
        idle(3, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
        idle(10, 1'b1);

        // Backpressure: result held, new samples refused while held.
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, a);
        idle(3, 1'b1);

        // Reset mid-frame discards the partial frame.
        send(8'h90, 1'b0, 1'b1);
        send(8'hC0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, a);
        send(8'h01, 1'b0, 1'b1);
        send(8'h02, 1'b0, 1'b1);
        send(8'h03, 1'b0, 1'b1);
        send(8'h04, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Flush together with an accepted sample includes that sample.
        send(8'h10, 1'b0, 1'b1);
        send(8'hEE, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0), a);
        end

        // Drain any pending result.
        idle(10, 1'b1);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
